// File: rtl/nn_pkg.sv
// Shared constants and sequencer state encoding for the NN inference test harness.
package nn_pkg;

  localparam int N_INPUTS  = 62;
  localparam int DATA_W    = 8;
  localparam int N_HIDDEN  = 20;
  localparam int N_OUTPUTS = 10;

  typedef enum logic [1:0] {
    LOAD,
    START,
    WAIT,
    CAPTURE
  } state_e;

endpackage

// File: rtl/nn_sample_assembler.sv
// Builds one sample frame (N_INPUTS data bytes, then the expected label); one byte per write,
// frame_done_o pulses combinationally while the label byte is being written.
module nn_sample_assembler #(
  parameter int N_INPUTS = 62,
  parameter int DATA_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en_i,
  input  logic [DATA_W-1:0]          wr_dat_i,
  output logic [N_INPUTS*DATA_W-1:0] vec_o,
  output logic [DATA_W-1:0]          exp_o,
  output logic                       frame_done_o
);

  localparam int IDX_W = $clog2(N_INPUTS + 1);

  logic [IDX_W-1:0]          idx_q;
  logic [N_INPUTS*DATA_W-1:0] vec_q;
  logic [DATA_W-1:0]          exp_q;
  logic                       last_byte;

  // The byte after the last data byte is the expected label, not part of the vector.
  assign last_byte    = (idx_q == IDX_W'(N_INPUTS));
  assign frame_done_o = wr_en_i && last_byte;
  assign vec_o        = vec_q;
  assign exp_o        = exp_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= '0;
      vec_q <= '0;
      exp_q <= '0;
    end else if (wr_en_i) begin
      if (last_byte) begin
        exp_q <= wr_dat_i;
        idx_q <= '0;
      end else begin
        vec_q[DATA_W*idx_q +: DATA_W] <= wr_dat_i;
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/nn_test_sequencer.sv
// Feeds assembled samples to the NN core, waits NN_LATENCY cycles, scores the returned label.
// Result strobe one cycle after CAPTURE; in_ready is low (input ignored) outside LOAD.
module nn_test_sequencer #(
  parameter int N_INPUTS   = nn_pkg::N_INPUTS,
  parameter int DATA_W     = nn_pkg::DATA_W,
  parameter int NN_LATENCY = 1300,
  parameter int CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  input  logic                       clr_stats,
  output logic [N_INPUTS*DATA_W-1:0] nn_data,
  output logic                       nn_start,
  input  logic [DATA_W-1:0]          nn_label,
  output logic                       pred_valid,
  output logic [DATA_W-1:0]          pred_label,
  output logic                       pred_correct,
  output logic [CNT_W-1:0]           total_count,
  output logic [CNT_W-1:0]           correct_count,
  output logic                       busy
);

  import nn_pkg::*;

  localparam int              WAIT_W  = (NN_LATENCY > 1) ? $clog2(NN_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state_q;
  logic [WAIT_W-1:0] wait_q;
  logic              rdy_q;
  logic              busy_q;
  logic              start_q;

  logic              pred_valid_q;
  logic [DATA_W-1:0] pred_label_q;
  logic              pred_correct_q;
  logic [CNT_W-1:0]  total_q, total_d;
  logic [CNT_W-1:0]  correct_q, correct_d;

  logic              wr_en;
  logic              frame_done;
  logic [DATA_W-1:0] exp_lbl;
  logic              capture;
  logic              label_match;

  assign wr_en = in_valid && rdy_q;

  nn_sample_assembler #(
    .N_INPUTS (N_INPUTS),
    .DATA_W   (DATA_W)
  ) u_assembler (
    .clk          (clk),
    .rst          (rst),
    .wr_en_i      (wr_en),
    .wr_dat_i     (in_data),
    .vec_o        (nn_data),
    .exp_o        (exp_lbl),
    .frame_done_o (frame_done)
  );

  // Outputs are registered alongside the state so each one changes exactly on its transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      wait_q  <= '0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        LOAD: begin
          if (frame_done) begin
            state_q <= START;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            rdy_q   <= 1'b0;
          end
        end
        START: begin
          wait_q  <= WAIT_W'(NN_LATENCY - 1);
          state_q <= WAIT;
        end
        WAIT: begin
          if (wait_q == '0) begin
            state_q <= CAPTURE;
          end else begin
            wait_q <= wait_q - WAIT_W'(1);
          end
        end
        CAPTURE: begin
          state_q <= LOAD;
          busy_q  <= 1'b0;
          rdy_q   <= 1'b1;
        end
        default: begin
          state_q <= LOAD;
          busy_q  <= 1'b0;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign capture     = (state_q == CAPTURE);
  assign label_match = (nn_label == exp_lbl);

  // A clear wins over a same-cycle capture; each counter sticks at its maximum independently.
  always_comb begin
    total_d   = total_q;
    correct_d = correct_q;
    if (clr_stats) begin
      total_d   = '0;
      correct_d = '0;
    end else if (capture) begin
      if (total_q != CNT_MAX) begin
        total_d = total_q + CNT_W'(1);
      end
      if (label_match && (correct_q != CNT_MAX)) begin
        correct_d = correct_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred_valid_q   <= 1'b0;
      pred_label_q   <= '0;
      pred_correct_q <= 1'b0;
      total_q        <= '0;
      correct_q      <= '0;
    end else begin
      pred_valid_q <= capture;
      if (capture) begin
        pred_label_q   <= nn_label;
        pred_correct_q <= label_match;
      end
      total_q   <= total_d;
      correct_q <= correct_d;
    end
  end

  assign in_ready      = rdy_q;
  assign busy          = busy_q;
  assign nn_start      = start_q;
  assign pred_valid    = pred_valid_q;
  assign pred_label    = pred_label_q;
  assign pred_correct  = pred_correct_q;
  assign total_count   = total_q;
  assign correct_count = correct_q;

endmodule

// File: tb/tb_nn_test_sequencer.sv
// Directed bench for nn_test_sequencer: two builds (16-bit and 4-bit counters) share one stimulus
// stream and are checked every cycle against a frame-level model of the sequencer.
module tb_nn_test_sequencer;

  localparam int N   = 62;
  localparam int DW  = 8;
  localparam int LAT = 16;
  localparam int VW  = N * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          clr_stats = 1'b0;
  logic [DW-1:0] nn_label = '0;
  logic [DW-1:0] stub = '0;

  logic          a_in_ready, a_nn_start, a_pred_valid, a_pred_correct, a_busy;
  logic [VW-1:0] a_nn_data;
  logic [DW-1:0] a_pred_label;
  logic [15:0]   a_total, a_correct;

  logic          b_in_ready, b_nn_start, b_pred_valid, b_pred_correct, b_busy;
  logic [VW-1:0] b_nn_data;
  logic [DW-1:0] b_pred_label;
  logic [3:0]    b_total, b_correct;

  always #5 clk = ~clk;

  nn_test_sequencer #(.N_INPUTS(N), .DATA_W(DW), .NN_LATENCY(LAT), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
    .clr_stats(clr_stats), .nn_data(a_nn_data), .nn_start(a_nn_start), .nn_label(nn_label),
    .pred_valid(a_pred_valid), .pred_label(a_pred_label), .pred_correct(a_pred_correct),
    .total_count(a_total), .correct_count(a_correct), .busy(a_busy)
  );

  nn_test_sequencer #(.N_INPUTS(N), .DATA_W(DW), .NN_LATENCY(LAT), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
    .clr_stats(clr_stats), .nn_data(b_nn_data), .nn_start(b_nn_start), .nn_label(nn_label),
    .pred_valid(b_pred_valid), .pred_label(b_pred_label), .pred_correct(b_pred_correct),
    .total_count(b_total), .correct_count(b_correct), .busy(b_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: busy_left counts the cycles still owed to the NN after a label byte.
  int            m_left;
  int            m_idx;
  logic [VW-1:0] m_vec;
  logic [DW-1:0] m_exp;
  logic [DW-1:0] m_pl;
  bit            m_pv, m_pc, m_cap;
  int            m_t16, m_c16, m_t4, m_c4;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left = 0; m_idx = 0; m_vec = '0; m_exp = '0; m_pl = '0;
      m_pv = 0; m_pc = 0; m_t16 = 0; m_c16 = 0; m_t4 = 0; m_c4 = 0;
    end else begin
      m_cap = (m_left == 1);
      m_pv  = m_cap;
      if (m_cap) begin
        m_pl = nn_label;
        m_pc = (nn_label == m_exp);
      end
      if (clr_stats) begin
        m_t16 = 0; m_c16 = 0; m_t4 = 0; m_c4 = 0;
      end else if (m_cap) begin
        if (m_t16 < 65535) m_t16++;
        if (m_t4 < 15) m_t4++;
        if (m_pc && m_c16 < 65535) m_c16++;
        if (m_pc && m_c4 < 15) m_c4++;
      end
      if (m_left > 0) begin
        m_left--;
      end else if (in_valid) begin
        if (m_idx < N) begin
          m_vec[DW*m_idx +: DW] = in_data;
          m_idx++;
        end else begin
          m_exp  = in_data;
          m_idx  = 0;
          m_left = LAT + 2;
        end
      end
    end
  end

  // Stub NN: the right answer only during the capture cycle, a corrupted one otherwise.
  always @(posedge clk) begin
    #1;
    nn_label = (m_left == 1) ? stub : (stub ^ 8'hA5);
  end

  bit chk_en = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a.in_ready", a_in_ready, m_left == 0);
      chk("a.busy", a_busy, m_left > 0);
      chk("a.nn_start", a_nn_start, m_left == LAT + 2);
      chk("a.nn_data", a_nn_data, m_vec);
      chk("a.pred_valid", a_pred_valid, m_pv);
      chk("a.pred_label", a_pred_label, m_pl);
      chk("a.pred_correct", a_pred_correct, m_pc);
      chk("a.total", a_total, m_t16);
      chk("a.correct", a_correct, m_c16);
      chk("b.in_ready", b_in_ready, m_left == 0);
      chk("b.busy", b_busy, m_left > 0);
      chk("b.nn_start", b_nn_start, m_left == LAT + 2);
      chk("b.nn_data", b_nn_data, m_vec);
      chk("b.pred_valid", b_pred_valid, m_pv);
      chk("b.pred_label", b_pred_label, m_pl);
      chk("b.pred_correct", b_pred_correct, m_pc);
      chk("b.total", b_total, m_t4);
      chk("b.correct", b_correct, m_c4);
    end
  end

  logic [DW-1:0] frame_buf [63];

  task automatic load_frame(input logic [DW-1:0] base, input logic [DW-1:0] step,
                            input logic [DW-1:0] lbl);
    for (int i = 0; i < N; i++) frame_buf[i] = base + DW'(i) * step;
    frame_buf[62] = lbl;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the label byte's accepting edge.
  task automatic send_frame(input bit toggle);
    int i = 0;
    int guard = 0;
    bit ph = 0;
    bit rdy;
    while (i < 63 && guard < 400) begin
      in_valid = toggle ? ph : 1'b1;
      in_data  = in_valid ? frame_buf[i] : 8'hEE;
      rdy      = (m_left == 0);
      @(posedge clk);
      if (in_valid && rdy) i++;
      ph = ~ph;
      guard++;
      #1;
    end
    in_valid = 1'b0;
    chk("frame bytes sent", i, 63);
  endtask

  // Waits for the result strobe; lat is the cycle index (START cycle = 0) where it was seen.
  task automatic wait_result(input bit hold, input bit clr, output int lat);
    bit got = 0;
    lat = -1;
    for (int k = 0; k < LAT + 10 && !got; k++) begin
      in_valid  = hold && (m_left > 0);
      in_data   = 8'hEE;
      clr_stats = clr && (m_left == 1);
      @(negedge clk);
      if (a_pred_valid) begin
        got = 1;
        lat = k;
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    clr_stats = 1'b0;
    chk("pred_valid seen", got, 1);
  endtask

  logic [DW-1:0] t3_lbl  [3] = '{8'd3, 8'd4, 8'd5};
  logic [DW-1:0] t3_stub [3] = '{8'd3, 8'd5, 8'd5};
  bit            t3_pc   [3] = '{1'b1, 1'b0, 1'b1};

  initial begin
    int lat;
    #2 rst = 1'b0;
    chk_en = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset in_ready", a_in_ready, 1);
    chk("reset total", a_total, 0);
    @(posedge clk);
    #1;

    // Single frame 0x01..0x3E, label 0x07, NN answers 0x07.
    load_frame(8'h01, 8'h01, 8'h07);
    stub = 8'h07;
    send_frame(0);
    wait_result(0, 0, lat);
    chk("t1 latency", lat, LAT + 2);
    chk("t1 byte0", a_nn_data[7:0], 8'h01);
    chk("t1 byte61", a_nn_data[495:488], 8'h3E);
    chk("t1 pred_label", a_pred_label, 8'h07);
    chk("t1 pred_correct", a_pred_correct, 1);
    chk("t1 total", a_total, 1);
    chk("t1 correct", a_correct, 1);

    // Reset in the middle of WAIT, then a normal frame.
    send_frame(0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst busy", a_busy, 0);
    chk("rst in_ready", a_in_ready, 1);
    chk("rst total", a_total, 0);
    chk("rst nn_data", a_nn_data, 0);
    chk("rst pred_label", a_pred_label, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    send_frame(0);
    wait_result(0, 0, lat);
    chk("post-rst total", a_total, 1);
    chk("post-rst correct", a_correct, 1);

    // Idle clear, then three frames: expected 3,4,5 against answers 3,5,5.
    clr_stats = 1'b1;
    @(posedge clk);
    #1 clr_stats = 1'b0;
    chk("idle clr total", a_total, 0);
    for (int f = 0; f < 3; f++) begin
      load_frame(8'h40 + DW'(f), 8'h02, t3_lbl[f]);
      stub = t3_stub[f];
      send_frame(0);
      wait_result(0, 0, lat);
      chk("t3 pred_correct", a_pred_correct, t3_pc[f]);
      chk("t3 pred_label", a_pred_label, t3_stub[f]);
    end
    chk("t3 total", a_total, 3);
    chk("t3 correct", a_correct, 2);

    // in_valid toggled during load and held high through WAIT.
    load_frame(8'h11, 8'h03, 8'h09);
    stub = 8'h09;
    send_frame(1);
    wait_result(1, 0, lat);
    chk("t4 byte10", a_nn_data[87:80], 8'h2F);
    chk("t4 byte61", a_nn_data[495:488], 8'hC8);
    chk("t4 total", a_total, 4);
    chk("t4 correct", a_correct, 3);

    // clr_stats coinciding with CAPTURE.
    load_frame(8'h80, 8'h01, 8'h02);
    stub = 8'h02;
    send_frame(0);
    wait_result(0, 1, lat);
    chk("t5 latency", lat, LAT + 2);
    chk("t5 total", a_total, 0);
    chk("t5 correct", a_correct, 0);
    chk("t5 pred_correct", a_pred_correct, 1);

    // 17 correct frames saturate the 4-bit build, then one wrong frame.
    stub = 8'h33;
    for (int f = 0; f < 17; f++) begin
      load_frame(DW'(f), 8'h05, 8'h33);
      send_frame(0);
      wait_result(0, 0, lat);
    end
    chk("sat b.total", b_total, 15);
    chk("sat b.correct", b_correct, 15);
    chk("sat a.total", a_total, 17);
    chk("sat a.correct", a_correct, 17);
    stub = 8'h34;
    load_frame(8'h21, 8'h01, 8'h33);
    send_frame(0);
    wait_result(0, 0, lat);
    chk("sat wrong b.total", b_total, 15);
    chk("sat wrong b.correct", b_correct, 15);
    chk("sat wrong a.total", a_total, 18);
    chk("sat wrong a.correct", a_correct, 17);
    chk("sat wrong pred_correct", a_pred_correct, 0);

    @(negedge clk);
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nn_test_sequencer.md
# nn_test_sequencer

Upstream feeder and result collector for the NN inference core. Accepts a byte-serial test-sample stream, assembles the 62-byte input vector that drives `reshaped_test_data`, pulses `start`, waits the fixed NN latency, samples `label`, compares it with the expected label carried in the stream, and keeps running total and correct counts for on-board accuracy measurement.

## Interface
Parameters:
- N_INPUTS, 62, input bytes per sample (vector width N_INPUTS*DATA_W)
- DATA_W, 8, bits per input byte and per label
- NN_LATENCY, 1300, cycles from `nn_start` to a valid `nn_label`; must be ≥ the NN core's worst-case latency
- CNT_W, 16, width of the statistics counters

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  stream byte valid
- in_data  in  DATA_W  stream byte
- in_ready  out  1  sequencer accepts a byte this cycle
- clr_stats  in  1  synchronous clear of both counters
- nn_data  out  N_INPUTS*DATA_W  to NN `reshaped_test_data`
- nn_start  out  1  to NN `start`
- nn_label  in  DATA_W  from NN `label`
- pred_valid  out  1  one-cycle result strobe
- pred_label  out  DATA_W  captured NN label
- pred_correct  out  1  pred_label == expected label
- total_count  out  CNT_W  samples evaluated
- correct_count  out  CNT_W  samples with pred_correct
- busy  out  1  high in START, WAIT, CAPTURE

## Operation
- Sample frame: N_INPUTS data bytes then 1 expected-label byte (63 bytes). Byte i (0-based) written to nn_data[DATA_W*i +: DATA_W]; byte 62 to internal expected register.
- FSM: LOAD → START → WAIT → CAPTURE → LOAD.
  - LOAD: in_ready=1; byte accepted when in_valid&in_ready; byte index increments; on acceptance of label byte go to START, index returns to 0.
  - START: nn_start=1 for exactly this cycle; wait counter loaded with NN_LATENCY-1.
  - WAIT: counter decrements; at 0 go to CAPTURE.
  - CAPTURE: pred_label<=nn_label, pred_correct<=(nn_label==expected), pred_valid=1 next cycle; total_count+1, correct_count+1 if equal.
- nn_data written only in LOAD; stable from START through CAPTURE.
- Counters saturate at 2^CNT_W-1 (no wrap); total and correct saturate independently.
- clr_stats has priority over a simultaneous CAPTURE increment: both counters become 0; pred_valid/pred_label/pred_correct still update.
- in_ready=0 outside LOAD; in_valid there is ignored (no buffering).
- Reset (any state, any time): state LOAD, index 0, nn_data 0, expected 0, nn_start 0, pred_valid 0, pred_label 0, pred_correct 0, both counters 0, busy 0, in_ready 1 after release.

## Timing
- Per-sample period with in_valid held high: 63 (load) + 1 (START) + NN_LATENCY (WAIT) + 1 (CAPTURE) cycles.
- nn_start asserts the cycle after the label byte is accepted.
- nn_label sampled NN_LATENCY+1 cycles after the nn_start cycle (first CAPTURE edge).
- pred_valid, pred_label, pred_correct and updated counters visible the cycle after CAPTURE; pred_label/pred_correct hold until next CAPTURE.
- in_ready returns high the cycle after CAPTURE.

## Structure
- Shared package nn_pkg: N_INPUTS, DATA_W, N_HIDDEN=20, N_OUTPUTS=10, state enum {LOAD, START, WAIT, CAPTURE}.
- One sub-module: nn_sample_assembler (byte index counter, vector register, expected-label register, frame-complete pulse). FSM, wait counter and statistics in the top.

## Test plan
- Reset mid-WAIT (rst low 3 cycles) → all outputs at reset values, in_ready=1, next frame processed normally.
- One frame bytes 0x01..0x3E, label 0x07; stub NN returns 0x07 → nn_data[7:0]=0x01, nn_data[495:488]=0x3E, nn_start one cycle, pred_valid at expected cycle, pred_correct=1, total=1, correct=1.
- Three frames, stub returns 3,5,5 vs expected 3,4,5 → pred_correct 1,0,1; total=3, correct=2.
- in_valid toggled every other cycle and held during WAIT → bytes only accepted in LOAD, nn_data unchanged during WAIT, frame assembled correctly.
- clr_stats asserted in CAPTURE cycle → counters 0, pred_valid still 1.
- Counters preloaded (CNT_W=4 build), 17 correct frames → both saturate at 15.
